// File: rtl/nvdla_mcif_sdp_rd_resp.sv
// MCIF read-return responder for the SDP read DMA. It reads burst atoms from a synchronous memory
// port, buffers them in a small FIFO, and returns them one beat at a time, gated by latency-FIFO credits.
module nvdla_mcif_sdp_rd_resp #(
    parameter int RFIFO_DEPTH = 4,
    parameter int LAT_DEPTH   = 8
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        sdp2mcif_rd_req_valid,
    output logic        sdp2mcif_rd_req_ready,
    input  logic [46:0] sdp2mcif_rd_req_pd,
    output logic        mcif2sdp_rd_rsp_valid,
    input  logic        mcif2sdp_rd_rsp_ready,
    output logic [64:0] mcif2sdp_rd_rsp_pd,
    input  logic        sdp2mcif_rd_cdt_lat_fifo_pop,
    output logic        mem_rd_en,
    output logic [28:0] mem_rd_addr,
    input  logic [63:0] mem_rd_data,
    output logic        cdt_overflow,
    output logic        busy
);
    localparam int PW = $clog2(RFIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          r_state, w_state_nxt;
    logic [28:0]     r_rd_addr;
    logic [15:0]     r_remaining;
    logic            r_inflight;
    logic [63:0]     r_fifo_mem [RFIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_credits;
    logic            r_cdt_overflow;

    logic            w_req_fire, w_room, w_push, w_xfer;
    logic            w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^sdp2mcif_rd_req_pd[2:0];
    assign w_req_fire = sdp2mcif_rd_req_valid && sdp2mcif_rd_req_ready;
    // Room is counted against both stored entries and the read whose data lands next cycle.
    assign w_room = ({1'b0, r_count} + (CW+1)'(r_inflight)) < (CW+1)'(RFIFO_DEPTH);
    assign w_push = r_inflight;
    assign w_xfer = mcif2sdp_rd_rsp_valid && mcif2sdp_rd_rsp_ready;

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) r_state <= S_IDLE;
        else                r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_fire) w_state_nxt = S_BURST;
            S_BURST: if (mem_rd_en && r_remaining == 16'd1) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sdp2mcif_rd_req_ready = 1'b0;
        mem_rd_en             = 1'b0;
        case (r_state)
            S_IDLE:  sdp2mcif_rd_req_ready = !nvdla_core_rst;
            S_BURST: mem_rd_en             = w_room && !nvdla_core_rst;
            default: ;
        endcase
    end

    // Address register is base + offset; it only moves on a handshake or an issued read.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= mem_rd_en;
            if (w_req_fire) begin
                r_rd_addr   <= sdp2mcif_rd_req_pd[31:3];
                r_remaining <= {1'b0, sdp2mcif_rd_req_pd[46:32]} + 16'd1;
            end else if (mem_rd_en) begin
                r_rd_addr   <= r_rd_addr + 29'd1;
                r_remaining <= r_remaining - 16'd1;
            end
        end
    end

    // NOTE: FIFO storage is left unreset; r_count alone decides which entries are visible.
    always_ff @(posedge nvdla_core_clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= mem_rd_data;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (!(w_push && r_count == CW'(RFIFO_DEPTH)));
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_xfer) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_xfer);
        end
    end

    // A returned credit at the ceiling saturates and flags the SDP-side accounting error.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_credits      <= 8'(LAT_DEPTH);
            r_cdt_overflow <= 1'b0;
        end else begin
            case ({w_xfer, sdp2mcif_rd_cdt_lat_fifo_pop})
                2'b10: r_credits <= r_credits - 8'd1;
                2'b01: begin
                    if (r_credits == 8'(LAT_DEPTH)) r_cdt_overflow <= 1'b1;
                    else                            r_credits      <= r_credits + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign mcif2sdp_rd_rsp_valid = (r_count != '0) && (r_credits != 8'd0);
    assign mcif2sdp_rd_rsp_pd    = (r_count != '0) ? {1'b1, r_fifo_mem[r_rd_ptr]} : '0;
    assign mem_rd_addr           = r_rd_addr;
    assign cdt_overflow          = r_cdt_overflow;
    assign busy                  = (r_state == S_BURST) || (r_count != '0) || r_inflight;
endmodule

// File: tb/tb_nvdla_mcif_sdp_rd_resp.sv
// Directed bench for nvdla_mcif_sdp_rd_resp: a synchronous memory model with address-derived data,
// and immediate assertions against hand-derived expectations, sampled 1 ns after each rising edge.
module tb_nvdla_mcif_sdp_rd_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [46:0] req_pd = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [64:0] rsp_pd;
    logic        cdt_pop = 1'b0;
    logic        mem_rd_en;
    logic [28:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        cdt_overflow;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_cyc, last_cyc, got;

    always #5 clk = ~clk;

    nvdla_mcif_sdp_rd_resp #(.RFIFO_DEPTH(4), .LAT_DEPTH(8)) dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rst               (rst),
        .sdp2mcif_rd_req_valid        (req_valid),
        .sdp2mcif_rd_req_ready        (req_ready),
        .sdp2mcif_rd_req_pd           (req_pd),
        .mcif2sdp_rd_rsp_valid        (rsp_valid),
        .mcif2sdp_rd_rsp_ready        (rsp_ready),
        .mcif2sdp_rd_rsp_pd           (rsp_pd),
        .sdp2mcif_rd_cdt_lat_fifo_pop (cdt_pop),
        .mem_rd_en                    (mem_rd_en),
        .mem_rd_addr                  (mem_rd_addr),
        .mem_rd_data                  (mem_rd_data),
        .cdt_overflow                 (cdt_overflow),
        .busy                         (busy)
    );

    function automatic logic [63:0] mem_f(input logic [28:0] a);
        return {3'b101, a, 3'b011, a ^ 29'h15555555};
    endfunction

    // Data is valid only the cycle after a strobe; any other cycle shows a poison pattern.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_f(mem_rd_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [14:0] size);
        for (int i = 0; i < 20 && !req_ready; i++) step();
        check("req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_pd    = {size, addr};
        step();
        req_valid = 1'b0;
        req_pd    = '0;
    endtask

    // Runs until n beats are taken or the cycle budget expires; checks addresses, data order, FIFO bound.
    task automatic collect(input logic [28:0] base, input int n, input int max_cyc,
                           input bit rnd, input bit apop, output int n_got);
        int          issued = 0;
        bit          prev   = 1'b0;
        logic [28:0] a;
        n_got = 0;
        for (int c = 0; c < max_cyc && n_got < n; c++) begin
            rsp_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            cdt_pop   = apop & prev;
            check("fifo_bound", dut.r_count <= 3'd4, 1'b1);
            if (mem_rd_en) begin
                a = base + 29'(issued);
                check("issue_addr", mem_rd_addr, a);
                check("issue_room", (dut.r_count + 3'(dut.r_inflight)) < 3'd4, 1'b1);
                issued++;
            end
            prev = rsp_valid && rsp_ready;
            if (prev) begin
                a = base + 29'(n_got);
                check("beat_pd", rsp_pd, {1'b1, mem_f(a)});
                if (n_got == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_got++;
            end
            step();
        end
        rsp_ready = 1'b0;
        cdt_pop   = apop & prev;
        if (cdt_pop) step();
        cdt_pop = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_ready", req_ready, 1'b0);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_pd", rsp_pd, 65'd0);
        check("rst_en", mem_rd_en, 1'b0);
        check("rst_addr", mem_rd_addr, 29'd0);
        check("rst_ovf", cdt_overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_credits", dut.r_credits, 8'd8);
        rst = 1'b0;
        step();
        check("ready_after_rst", req_ready, 1'b1);

        // Single atom: handshake T, read at T+1, ready at T+2, beat at T+3
        send_req(32'h0000_1000, 15'd0);
        check("single_en_t1", mem_rd_en, 1'b1);
        check("single_addr_t1", mem_rd_addr, 29'h200);
        check("single_ready_t1", req_ready, 1'b0);
        check("single_busy_t1", busy, 1'b1);
        step();
        check("single_ready_t2", req_ready, 1'b1);
        check("single_en_t2", mem_rd_en, 1'b0);
        check("single_valid_t2", rsp_valid, 1'b0);
        step();
        check("single_valid_t3", rsp_valid, 1'b1);
        check("single_pd_t3", rsp_pd, {1'b1, mem_f(29'h200)});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("single_credits", dut.r_credits, 8'd7);
        check("single_valid_done", rsp_valid, 1'b0);
        check("single_busy_done", busy, 1'b0);
        cdt_pop = 1'b1;
        step();
        cdt_pop = 1'b0;
        check("refill_credits", dut.r_credits, 8'd8);

        // Burst at full rate: 8 consecutive beats drain every credit
        send_req(32'h0000_0100, 15'd7);
        collect(29'h20, 8, 40, 1'b0, 1'b0, got);
        check("burst_beats", got, 8);
        check("burst_consecutive", last_cyc - first_cyc, 7);
        check("burst_credits", dut.r_credits, 8'd0);
        step();
        step();
        check("burst_no_valid", rsp_valid, 1'b0);
        check("burst_idle", busy, 1'b0);

        // Credit starvation: 12-atom burst, only 8 credits
        cdt_pop = 1'b1;
        repeat (8) step();
        cdt_pop = 1'b0;
        check("starve_refill", dut.r_credits, 8'd8);
        send_req(32'h0000_3000, 15'd11);
        collect(29'h600, 12, 25, 1'b0, 1'b0, got);
        check("starve_beats", got, 8);
        check("starve_valid", rsp_valid, 1'b0);
        check("starve_fifo", dut.r_count, 3'd4);
        check("starve_busy", busy, 1'b1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cdt_pop = 1'b1;
            step();
            cdt_pop = 1'b0;
            check("starve_pop_valid", rsp_valid, 1'b1);
            check("starve_pop_pd", rsp_pd, {1'b1, mem_f(29'h600 + 29'(8 + i))});
            step();
            check("starve_one_beat", rsp_valid, 1'b0);
        end
        rsp_ready = 1'b0;
        check("starve_drained", busy, 1'b0);
        cdt_pop = 1'b1;
        repeat (8) step();
        cdt_pop = 1'b0;

        // Backpressure: 30% ready duty, credits returned one cycle after each beat
        send_req(32'h0000_4000, 15'd31);
        collect(29'h800, 32, 600, 1'b1, 1'b1, got);
        check("bp_beats", got, 32);
        check("bp_credits", dut.r_credits, 8'd8);
        check("bp_idle", busy, 1'b0);
        check("bp_ovf", cdt_overflow, 1'b0);

        // Credit boundaries: pop with transfer, then pop at the ceiling
        send_req(32'h0000_0040, 15'd0);
        step();
        step();
        check("cb_valid", rsp_valid, 1'b1);
        check("cb_pd", rsp_pd, {1'b1, mem_f(29'h8)});
        rsp_ready = 1'b1;
        cdt_pop   = 1'b1;
        step();
        rsp_ready = 1'b0;
        cdt_pop   = 1'b0;
        check("cb_same_cycle_credits", dut.r_credits, 8'd8);
        check("cb_same_cycle_ovf", cdt_overflow, 1'b0);
        cdt_pop = 1'b1;
        step();
        cdt_pop = 1'b0;
        check("cb_sat_credits", dut.r_credits, 8'd8);
        check("cb_ovf_set", cdt_overflow, 1'b1);
        step();
        step();
        check("cb_ovf_sticky", cdt_overflow, 1'b1);

        // Address wrap at the top of the 29-bit atom space
        send_req(32'hFFFF_FFF8, 15'd1);
        check("wrap_first", mem_rd_addr, 29'h1FFF_FFFF);
        collect(29'h1FFF_FFFF, 2, 20, 1'b0, 1'b1, got);
        check("wrap_beats", got, 2);
        check("wrap_ovf_held", cdt_overflow, 1'b1);

        // Reset in the middle of a 16-atom burst
        send_req(32'h0000_2000, 15'd15);
        collect(29'h400, 3, 30, 1'b0, 1'b1, got);
        check("mid_beats", got, 3);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        check("mid_rst_ready", req_ready, 1'b0);
        check("mid_rst_valid", rsp_valid, 1'b0);
        check("mid_rst_pd", rsp_pd, 65'd0);
        check("mid_rst_en", mem_rd_en, 1'b0);
        check("mid_rst_addr", mem_rd_addr, 29'd0);
        check("mid_rst_ovf", cdt_overflow, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_credits", dut.r_credits, 8'd8);
        rst = 1'b0;
        step();
        check("post_rst_ready", req_ready, 1'b1);
        check("post_rst_drop", rsp_valid, 1'b0);
        step();
        check("post_rst_empty", busy, 1'b0);
        send_req(32'h0000_0080, 15'd2);
        collect(29'h10, 3, 30, 1'b0, 1'b1, got);
        check("post_rst_beats", got, 3);
        check("post_rst_credits", dut.r_credits, 8'd8);
        check("post_rst_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/nvdla_mcif_sdp_rd_resp.md
# nvdla_mcif_sdp_rd_resp

Memory-side responder for the SDP read-DMA channel (sdp2mcif_rd_req / mcif2sdp_rd_rsp / sdp2mcif_rd_cdt_lat_fifo_pop). It accepts one burst request at a time and reads the requested 64-bit atoms from a synchronous backing-memory port. Each atom is buffered in a small return FIFO and returned to SDP one beat per handshake. Beats are gated by a credit counter that mirrors SDP's read latency FIFO. It is used both as the MCIF read-return endpoint in unit-level SDP environments and as the read side of the on-chip memory model.

## Interface
Parameters:
- RFIFO_DEPTH, 4: return FIFO entries, power of two, ≥2.
- LAT_DEPTH, 8: SDP latency-FIFO depth, which is the initial and maximum credit count; ≤255.

Ports:
- nvdla_core_clk  in  1  sole clock, all state on rising edge.
- nvdla_core_rst  in  1  synchronous, active-high reset.
- sdp2mcif_rd_req_valid  in  1  request valid.
- sdp2mcif_rd_req_ready  out  1  request accept.
- sdp2mcif_rd_req_pd  in  47  [31:0] byte address, atom-aligned, addr[2:0] ignored; [46:32] size = atoms−1.
- mcif2sdp_rd_rsp_valid  out  1  response beat valid.
- mcif2sdp_rd_rsp_ready  in  1  response beat accept.
- mcif2sdp_rd_rsp_pd  out  65  [63:0] data; [64] mask, always 1.
- sdp2mcif_rd_cdt_lat_fifo_pop  in  1  one credit returned per cycle high.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  29  atom index, equal to addr[31:3] + beat offset.
- mem_rd_data  in  64  valid exactly one cycle after mem_rd_en.
- cdt_overflow  out  1  sticky error, set when a credit pop arrives while credits == LAT_DEPTH.
- busy  out  1  high in BURST state, when the FIFO is non-empty, or when a read is in flight.

## Operation
- **FSM states:** IDLE and BURST.
  - sdp2mcif_rd_req_ready = (state==IDLE) && !nvdla_core_rst.
  - On a request handshake, latch base = pd[31:3] and remaining = pd[46:32]+1 (16-bit), reset beat offset to 0, and go to BURST.
- **Issuing reads in BURST:** assert mem_rd_en in every cycle where inflight + fifo_count < RFIFO_DEPTH.
  - inflight is the 1-bit count of reads issued in the previous cycle.
  - mem_rd_addr = base + offset, modulo 2^29, so the address wraps silently from 0x1FFFFFFF to 0.
  - Each issued read increments offset and decrements remaining.
  - When the read with remaining==1 issues, go to IDLE in the next cycle.
- **FIFO write:** the cycle after mem_rd_en, mem_rd_data is written into the FIFO with mask=1.
  - The FIFO has no bypass.
  - The full condition cannot occur by construction; an assertion checks it.
- **Output side:** mcif2sdp_rd_rsp_valid = fifo non-empty && credits != 0.
  - pd is the FIFO head.
  - valid&ready pops the FIFO and decrements credits.
- **Credits:** 8-bit counter, reset to LAT_DEPTH.
  - A pop input increments it.
  - Transfer and pop in the same cycle leave it unchanged.
  - A pop while credits==LAT_DEPTH with no transfer that cycle leaves the counter saturated and sets cdt_overflow.
  - cdt_overflow clears only on reset.
- **Back-to-back requests:** a new request may be accepted in IDLE while earlier beats still drain from the FIFO. Return ordering is strict FIFO.
- **Reset mid-operation:** within the same cycle, reset aborts any burst, empties the FIFO, and discards an in-flight read. The memory data returned in the following cycle is dropped.

## Timing
- **Reset values:** sdp2mcif_rd_req_ready=0, mcif2sdp_rd_rsp_valid=0, pd=0, mem_rd_en=0, mem_rd_addr=0, cdt_overflow=0, busy=0, credits=LAT_DEPTH.
- **After reset:** ready rises in the first cycle after reset deasserts.
- **Latency:** request handshake in cycle T gives mem_rd_en at T+1, mem_rd_data at T+2, FIFO write at the end of T+2, and rsp_valid at T+3.
- **Throughput:** one beat per cycle sustained when ready=1 and credits>0.
- **Stalls:** under backpressure, read issue stalls at most 1 cycle after the FIFO fills. mem_rd_addr is held while mem_rd_en=0.
- **Next request:** ready returns in the cycle after the last read issues.
- **Stable valid:** once valid is asserted, pd is stable until the handshake. A credit pop never deasserts valid.

## Test plan
- **Single atom:** addr 0x00001000, size 0 → mem_rd_addr 0x200 at T+1; one beat at T+3 with pd = {1'b1, mem data}; credits 8→7; ready back at T+2.
- **Burst, full rate:** addr 0x100, size 7, ready=1, no pops → 8 consecutive beats for mem_rd_addr 0x20..0x27; credits reach 0; no further valid until a pop.
- **Credit starvation:** LAT_DEPTH=8, size 11, no pops → exactly 8 beats, then valid=0 while the FIFO holds 4. Each pop releases exactly one beat, and the 12 beats arrive in order.
- **Backpressure:** random ready at 30% duty, size 31 → 32 beats in order with no loss or duplication; FIFO never exceeds RFIFO_DEPTH; mem_rd_en never asserts with FIFO count + inflight == RFIFO_DEPTH.
- **Credit boundary cases:**
  - Pop in the same cycle as a transfer → credits unchanged.
  - Pop at credits==8 → credits stay 8 and cdt_overflow=1 until reset.
- **Address wrap and reset:**
  - addr 0xFFFFFFF8, size 1 → mem_rd_addr 0x1FFFFFFF, then 0x0.
  - Reset asserted at beat 3 of a size-15 burst → all outputs at reset values the next cycle, credits=8, and a new request is serviced cleanly afterwards.
